// File: rtl/sram_controller.sv
// Bus responder for one asynchronous SRAM bank: accepts single-cycle read/write
// requests, sequences ce_n/oe_n/we_n with fixed cycle counts and returns a one-cycle ack.
module sram_controller #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int READ_CYCLES = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_req,
    input  logic                    bus_we,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH/8-1:0] bus_be,
    output logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    bus_ack,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_dout,
    output logic                    sram_dout_en,
    input  logic [DATA_WIDTH-1:0]   sram_din,
    output logic                    sram_ce_n,
    output logic                    sram_oe_n,
    output logic                    sram_we_n,
    output logic [DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int MAX_CYC = (READ_CYCLES > WRITE_PULSE) ? READ_CYCLES : WRITE_PULSE;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_PULSE - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_ACK      = 3'd5;

    logic [2:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] dout_q,    dout_d;
    logic                  dout_en_q, dout_en_d;
    logic                  ce_n_q,    ce_n_d;
    logic                  oe_n_q,    oe_n_d;
    logic                  we_n_q,    we_n_d;
    logic [BE_W-1:0]       be_n_q,    be_n_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic                  ack_q,     ack_d;
    logic                  busy_q,    busy_d;

    // Every pin value is computed for the state being entered, so all outputs
    // come straight from flops and the request fields need no separate latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        dout_en_d = dout_en_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        be_n_d    = be_n_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                if (bus_req) begin
                    busy_d = 1'b1;
                    addr_d = bus_addr;
                    ce_n_d = 1'b0;
                    if (bus_we) begin
                        dout_d    = bus_wdata;
                        dout_en_d = 1'b1;
                        be_n_d    = ~bus_be;
                        state_d   = S_WR_SETUP;
                    end else begin
                        oe_n_d  = 1'b0;
                        be_n_d  = '0;
                        cnt_d   = RD_LAST;
                        state_d = S_RD;
                    end
                end
            end

            S_RD: begin
                if (cnt_q == '0) begin
                    rdata_d = sram_din;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    be_n_d  = '1;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_LAST;
                state_d = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (cnt_q == '0) begin
                    we_n_d  = 1'b1;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_WR_HOLD: begin
                ce_n_d    = 1'b1;
                dout_en_d = 1'b0;
                be_n_d    = '1;
                ack_d     = 1'b1;
                state_d   = S_ACK;
            end

            S_ACK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                be_n_d    = '1;
                dout_en_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= '1;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_rdata    = rdata_q;
    assign bus_ack      = ack_q;
    assign busy         = busy_q;
    assign sram_addr    = addr_q;
    assign sram_dout    = dout_q;
    assign sram_dout_en = dout_en_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_be_n    = be_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed + random bench for sram_controller with an attached SRAM pin model and a
// transaction-level reference memory.
module tb_sram_controller;

    localparam int RC = 2;
    localparam int WP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [19:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        busy;
    logic [19:0] sram_addr;
    logic [31:0] sram_dout;
    logic        sram_dout_en;
    logic [31:0] sram_din;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_count = 0;
    int we_low_count = 0;
    logic [31:0] last_rdata;

    logic [31:0] sram_mem [logic [19:0]];
    logic [31:0] ref_mem  [logic [19:0]];
    logic [31:0] model_w;

    sram_controller #(
        .ADDR_WIDTH (20),
        .DATA_WIDTH (32),
        .READ_CYCLES(RC),
        .WRITE_PULSE(WP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .busy        (busy),
        .sram_addr   (sram_addr),
        .sram_dout   (sram_dout),
        .sram_dout_en(sram_dout_en),
        .sram_din    (sram_din),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_be_n   (sram_be_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic ref_write(input logic [19:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v;
        v = ref_read(a);
        for (int i = 0; i < 4; i++)
            if (be[i]) v[i*8 +: 8] = wd[i*8 +: 8];
        ref_mem[a] = v;
    endtask

    // Asynchronous SRAM pin model: writes lanes while we_n is low, drives data while oe_n is low.
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            model_w = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (!sram_be_n[i]) model_w[i*8 +: 8] = sram_dout[i*8 +: 8];
            sram_mem[sram_addr] = model_w;
        end
        if (!sram_ce_n && !sram_oe_n)
            sram_din = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : 32'h0;
        else
            sram_din = 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin
        if (bus_ack) ack_count++;
        if (!sram_we_n) we_low_count++;
        if (rst) begin
            check("oe_we_exclusive", 64'(sram_oe_n | sram_we_n), 64'd1);
            check("dout_en_only_oe_high", 64'(!sram_dout_en | sram_oe_n), 64'd1);
        end
    end

    task automatic do_access(input logic we, input logic [19:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
        int k;
        int lat_exp;
        logic done;
        logic exp_we_n;
        logic [31:0] exp_rd;
        lat_exp = we ? WP + 3 : RC + 1;
        exp_rd  = ref_read(a);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_be = be;
        @(posedge clk);
        #1;
        bus_req = 1'b0; bus_addr = 20'($urandom); bus_wdata = $urandom; bus_be = 4'($urandom);
        k = 0;
        done = 1'b0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
            if (bus_ack) done = 1'b1;
            else if (we) begin
                exp_we_n = !(k >= 2 && k <= WP + 1);
                check("wr_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, sram_be_n, sram_addr, sram_dout},
                      {1'b0, 1'b1, exp_we_n, 1'b1, ~be, a, wd});
            end else begin
                check("rd_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, sram_be_n, sram_addr},
                      {4'b0010, 4'h0, a});
            end
        end
        check(we ? "wr_latency" : "rd_latency", 64'(k), 64'(lat_exp));
        check("ack_pins", {busy, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, sram_be_n},
              {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hF});
        if (!we) begin
            check("rdata", bus_rdata, exp_rd);
            last_rdata = exp_rd;
        end else begin
            check("rdata_kept_on_write", bus_rdata, last_rdata);
            ref_write(a, wd, be);
        end
        @(negedge clk);
        check("post_ack_idle", {bus_ack, busy}, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        int wl0;
        int k;
        rst = 1'b0; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
        last_rdata = 32'h0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, bus_ack, busy, sram_be_n},
              {6'b111000, 4'hF});
        check("reset_data", {sram_addr, sram_dout}, 52'h0);
        check("reset_rdata", bus_rdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        do_access(1'b1, 20'h00123, 32'hDEADBEEF, 4'hF);
        do_access(1'b0, 20'h00123, 32'h0, 4'hF);
        check("readback_deadbeef", bus_rdata, 32'hDEADBEEF);

        do_access(1'b1, 20'h00200, 32'h11223344, 4'hF);
        do_access(1'b1, 20'h00200, 32'hAABBCCDD, 4'b0101);
        do_access(1'b0, 20'h00200, 32'h0, 4'hF);
        check("byte_merge", bus_rdata, 32'h11BB33DD);

        do_access(1'b1, 20'h00123, 32'h55555555, 4'h0);
        do_access(1'b0, 20'h00123, 32'h0, 4'hF);
        check("be_zero_no_change", bus_rdata, 32'hDEADBEEF);

        do_access(1'b1, 20'hFFFFF, 32'h00000001, 4'hF);
        do_access(1'b0, 20'hFFFFF, 32'h0, 4'h0);
        check("max_addr_readback", bus_rdata, 32'h00000001);

        // Request while busy: the second strobe must be dropped
        do_access(1'b1, 20'h00010, 32'hCAFEF00D, 4'hF);
        acks0 = ack_count;
        wl0 = we_low_count;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 20'h00010; bus_be = 4'hF;
        @(posedge clk);
        #1;
        bus_we = 1'b1; bus_addr = 20'h00020; bus_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_single_ack", 64'(ack_count - acks0), 64'd1);
        check("busy_no_write", 64'(we_low_count - wl0), 64'd0);
        check("busy_rdata", bus_rdata, ref_read(20'h00010));
        last_rdata = ref_read(20'h00010);
        do_access(1'b0, 20'h00020, 32'h0, 4'hF);

        // Asynchronous reset in the middle of a write pulse
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 20'h00777; bus_wdata = 32'h0F0F0F0F; bus_be = 4'hF;
        @(posedge clk);
        #1;
        bus_req = 1'b0;
        k = 0;
        while (sram_we_n && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("we_pulse_seen", 64'(sram_we_n), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_pins", {sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en, busy, bus_ack, sram_be_n},
              {6'b111000, 4'hF});
        check("async_reset_rdata", bus_rdata, 32'h0);
        last_rdata = 32'h0;
        acks0 = ack_count;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("no_ack_after_reset", 64'(ack_count - acks0), 64'd0);
        check("idle_after_reset", {busy, sram_ce_n, sram_we_n}, 3'b011);

        for (int i = 0; i < 40; i++) begin
            do_access(1'($urandom_range(0, 1)), 20'h00100 + 20'($urandom_range(0, 7)), $urandom,
                      4'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 8; i++) begin
            do_access(1'b0, 20'h00100 + 20'(i), 32'h0, 4'hF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Bus responder between the CPU-side memory bus and one external asynchronous SRAM bank: 20-bit word address, 32-bit data, byte enables.
- Accepts single-cycle read/write requests from the bus initiator and sequences the SRAM strobes with fixed cycle counts.
- Returns a one-cycle acknowledge with read data.
- The top level turns sram_dout/sram_dout_en into the tri-state data pins. This block contains no inout.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width.
- DATA_WIDTH, 32, data width. Must be a multiple of 8.
- READ_CYCLES, 2, clock cycles oe_n is held low before data is sampled. Minimum 1.
- WRITE_PULSE, 2, clock cycles we_n is held low. Minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bus_req  in  1  one-cycle request strobe. Only honoured when busy=0.
- bus_we  in  1  1=write, 0=read. Sampled with bus_req.
- bus_addr  in  ADDR_WIDTH  word address. Sampled with bus_req.
- bus_wdata  in  DATA_WIDTH  write data. Sampled with bus_req.
- bus_be  in  DATA_WIDTH/8  active-high byte enables for writes. Sampled with bus_req.
- bus_rdata  out  DATA_WIDTH  read data. Valid from the ack cycle until the next read completes.
- bus_ack  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance through the ack cycle.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_dout  out  DATA_WIDTH  data driven to SRAM.
- sram_dout_en  out  1  data pin drive enable.
- sram_din  in  DATA_WIDTH  data from SRAM pins.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_be_n  out  DATA_WIDTH/8  byte enables, active low.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, also mid-access):
  - State IDLE; ce_n=oe_n=we_n=1; be_n all ones; dout_en=0.
  - sram_addr=0, sram_dout=0, bus_rdata=0, bus_ack=0, busy=0.
  - No partial cycle resumes after reset release.
- All outputs are registered. Counter width is $clog2(max(READ_CYCLES,WRITE_PULSE)+1).
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE:
  - On an edge with bus_req=1, latch addr/wdata/be/we and set busy=1.
  - bus_we=0 goes to RD; bus_we=1 goes to WR_SETUP.
  - bus_req while busy=1 is ignored: no queueing, no error.
- Read, with the request accepted at edge N:
  - After N: ce_n=0, oe_n=0, be_n=0 (all lanes; bus_be ignored), sram_addr=latched address.
  - Stay in RD for READ_CYCLES cycles.
  - At edge N+READ_CYCLES: capture sram_din into bus_rdata, ce_n=oe_n=1, be_n all ones, go to ACK.
- Write, with the request accepted at edge N:
  - After N (WR_SETUP, 1 cycle): ce_n=0, we_n=1, sram_addr/sram_dout=latched values, dout_en=1, be_n=~be.
  - After N+1 (WR_PULSE): we_n=0 for WRITE_PULSE cycles.
  - After N+1+WRITE_PULSE (WR_HOLD, 1 cycle): we_n=1; ce_n, addr, data, dout_en unchanged.
  - At edge N+2+WRITE_PULSE: ce_n=1, dout_en=0, be_n all ones, go to ACK.
- ACK: bus_ack=1 for exactly one cycle, busy=1, all strobes inactive. Next edge: IDLE, busy=0, ack=0.
- Latency from acceptance edge to ack-high cycle:
  - Read: READ_CYCLES+1 cycles (3 at defaults).
  - Write: WRITE_PULSE+3 cycles (5 at defaults).
- Back-to-back requests: the earliest next accept is the first edge with busy=0, i.e. one cycle after the ack cycle.
- oe_n and we_n are never low simultaneously. dout_en=1 only when oe_n=1.
- Write with bus_be=0: full cycle runs with be_n all ones, no data changes, normal ack.
- bus_rdata is not modified by writes.
- Address at maximum (all ones) is passed through unchanged. There is no wrap or increment logic.

Test Plan:
- Reset: hold rst=0, toggle clk 5 cycles -> ce_n/oe_n/we_n=1, be_n=4'hF, dout_en=0, ack=0, busy=0.
- Write then read: write addr=20'h00123, data=32'hDEADBEEF, be=4'hF, with SRAM model attached.
  - Write: ack 5 cycles after accept; we_n low exactly 2 cycles; data stable through setup and hold.
  - Read of addr=20'h00123: ack 3 cycles after accept, bus_rdata=32'hDEADBEEF.
- Byte write: preload 32'h11223344, write 32'hAABBCCDD with be=4'b0101 -> be_n=4'b1010 during WR_PULSE; readback=32'h11BB33DD.
- Request while busy: pulse a read to 20'h00010, then a second bus_req 1 cycle later -> only one access is performed and one ack is seen.
  - A new request issued the cycle after ack is accepted.
- Reset mid-write: assert rst=0 during WR_PULSE -> we_n, ce_n go high and dout_en goes low without a clock edge.
  - After release: IDLE, no ack.
- Boundary address: write/read 20'hFFFFF with data 32'h00000001 -> sram_addr=20'hFFFFF during the cycle, readback 32'h00000001; a read with be=0 still uses be_n=4'h0.
